// File: rtl/register_file_we.sv
// ---------------------------------------------------------------------------
// register_file_we
//   Operand store for the single-cycle datapath: DEPTH registers of W bits.
//   It has one synchronous write port and two independent combinational read
//   ports, which feed the two ALU source operands.
//
// Parameters
//   W        data width of each register
//   DEPTH    number of registers (2..256)
//   AW       address width, $clog2(DEPTH)
//   ZERO_R0  when nonzero, register 0 is hard-wired to zero
//
// Ports
//   clk      system clock, all state changes on the rising edge
//   rst      synchronous active-high reset, clears every register, beats we
//   we       write enable
//   waddr    write address
//   wdata    write data
//   raddr_a  read address, port A      rdata_a  read data, port A
//   raddr_b  read address, port B      rdata_b  read data, port B
//
// Optional feature
//   REGFILE_BYPASS_EN  when defined, an accepted write in the current cycle is
//                      forwarded straight to any read port that addresses the
//                      write target. Storage behaviour is the same either way.
// ---------------------------------------------------------------------------
module register_file_we #(
  parameter int W       = 8,
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH),
  parameter int ZERO_R0 = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [W-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_b
);

  // The comparison gets one extra bit so that DEPTH itself is representable.
  // This holds even when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [W-1:0] mem_r [DEPTH];
  logic         wr_ok_s;
  logic         byp_a_s;
  logic         byp_b_s;
  logic [W-1:0] rdata_a_s;
  logic [W-1:0] rdata_b_s;

  // An address is live when it is in range and is not a hard-wired zero r0.
  // Reads and writes share this rule.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_C) &&
           !((ZERO_R0 != 0) && (addr == {AW{1'b0}}));
  endfunction

  // A write takes effect only when it is enabled and aimed at a live register.
  always_comb begin
    wr_ok_s = 1'b0;
    if (we && addr_ok(waddr)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the write data when an accepted, non-reset write targets this port.
  always_comb begin
    byp_a_s = 1'b0;
    byp_b_s = 1'b0;
    if (wr_ok_s && !rst) begin
      byp_a_s = (raddr_a == waddr);
      byp_b_s = (raddr_b == waddr);
    end else begin
      byp_a_s = 1'b0;
      byp_b_s = 1'b0;
    end
  end
`else
  // Without the bypass, the ports always show the stored contents.
  always_comb begin
    byp_a_s = 1'b0;
    byp_b_s = 1'b0;
  end
`endif

  // Storage update: a reset clears everything and drops any concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port A: bypass first, then storage, and zero for dead addresses.
  always_comb begin
    rdata_a_s = {W{1'b0}};
    if (byp_a_s) begin
      rdata_a_s = wdata;
    end else if (addr_ok(raddr_a)) begin
      rdata_a_s = mem_r[raddr_a];
    end else begin
      rdata_a_s = {W{1'b0}};
    end
  end

  // Read port B: same priority as port A, but it is resolved independently.
  always_comb begin
    rdata_b_s = {W{1'b0}};
    if (byp_b_s) begin
      rdata_b_s = wdata;
    end else if (addr_ok(raddr_b)) begin
      rdata_b_s = mem_r[raddr_b];
    end else begin
      rdata_b_s = {W{1'b0}};
    end
  end

  assign rdata_a = rdata_a_s;
  assign rdata_b = rdata_b_s;

endmodule

// File: tb/tb_register_file_we.sv
// ---------------------------------------------------------------------------
// tb_register_file_we
//   Directed bench for register_file_we. It drives three instances:
//     u0  default (W=8, DEPTH=8)
//     u1  ZERO_R0=1
//     u2  DEPTH=6
//   The write data, addresses and reset are shared by all three. Each
//   instance has its own write enable. Expected read values are queued as
//   each step is driven, then popped and compared once the inputs settle.
// ---------------------------------------------------------------------------
module tb_register_file_we;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       we0, we1, we2;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata;
  logic [7:0] ra0, rb0, ra1, rb1, ra2, rb2;

  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      tag;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  register_file_we #(.W(8), .DEPTH(8)) u0 (
    .clk(clk), .rst(rst), .we(we0), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ra0), .raddr_b(raddr_b), .rdata_b(rb0));

  register_file_we #(.W(8), .DEPTH(8), .ZERO_R0(1)) u1 (
    .clk(clk), .rst(rst), .we(we1), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ra1), .raddr_b(raddr_b), .rdata_b(rb1));

  register_file_we #(.W(8), .DEPTH(6)) u2 (
    .clk(clk), .rst(rst), .we(we2), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(ra2), .raddr_b(raddr_b), .rdata_b(rb2));

  // sel: 0=u0.a 1=u0.b 2=u1.a 3=u1.b 4=u2.a 5=u2.b
  task automatic push(input int sel, input logic [7:0] exp, input string tag);
    sb_t e;
    e.sel = sel;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t        e;
    logic [7:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = ra0;
        1:       obs = rb0;
        2:       obs = ra1;
        3:       obs = rb1;
        4:       obs = ra2;
        5:       obs = rb2;
        default: obs = 8'hxx;
      endcase
      n_checks++;
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    waddr = 3'd0; wdata = 8'h00; raddr_a = 3'd0; raddr_b = 3'd0;
    tick();
    rst = 1'b0;

    // Preload mem[3]=A5, then reset and check that every address reads zero.
    we0 = 1'b1; waddr = 3'd3; wdata = 8'hA5;
    tick();
    we0 = 1'b0; raddr_a = 3'd3;
    push(0, 8'hA5, "preload");
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(i);
      push(0, 8'h00, $sformatf("rst_a%0d", i));
      push(1, 8'h00, $sformatf("rst_b%0d", i));
      drain();
    end

    // Basic write/read, then hold with we=0 and junk data on wdata.
    we0 = 1'b1; waddr = 3'd5; wdata = 8'h3C; raddr_a = 3'd5;
    push(0, BYP ? 8'h3C : 8'h00, "wr5_pre");
    drain();
    tick();
    we0 = 1'b0; wdata = 8'hFF;
    push(0, 8'h3C, "wr5_post");
    drain();
    tick(); tick();
    push(0, 8'h3C, "wr5_hold");
    drain();

    // Dual reads: different addresses on each port, then the same one.
    we0 = 1'b1; waddr = 3'd1; wdata = 8'h11;
    tick();
    waddr = 3'd6; wdata = 8'h66;
    tick();
    we0 = 1'b0; raddr_a = 3'd1; raddr_b = 3'd6;
    push(0, 8'h11, "dual_a"); push(1, 8'h66, "dual_b");
    drain();
    raddr_a = 3'd6;
    push(0, 8'h66, "same_a"); push(1, 8'h66, "same_b");
    drain();

    // Read the write target in the same cycle as the write.
    we0 = 1'b1; waddr = 3'd2; wdata = 8'h10;
    tick();
    waddr = 3'd2; wdata = 8'h20; raddr_a = 3'd2; raddr_b = 3'd1;
    push(0, BYP ? 8'h20 : 8'h10, "row_pre");
    push(1, 8'h11, "row_other");
    drain();
    tick();
    we0 = 1'b0;
    push(0, 8'h20, "row_post");
    drain();

    // Reset beats write. During the reset cycle nothing is bypassed.
    we0 = 1'b1; waddr = 3'd4; wdata = 8'h99;
    tick();
    rst = 1'b1; wdata = 8'h77; raddr_a = 3'd4;
    push(0, 8'h99, "prio_pre");
    drain();
    tick();
    rst = 1'b0; we0 = 1'b0; raddr_b = 3'd5;
    push(0, 8'h00, "prio_mem4"); push(1, 8'h00, "prio_mem5");
    drain();

    // Back-to-back writes to one address: the last edge wins.
    we0 = 1'b1; waddr = 3'd7; wdata = 8'h01;
    tick();
    wdata = 8'h02;
    tick();
    we0 = 1'b0; raddr_a = 3'd7;
    push(0, 8'h02, "b2b");
    drain();

    // ZERO_R0: writes to r0 are discarded, and other registers still work.
    we1 = 1'b1; waddr = 3'd0; wdata = 8'h55; raddr_a = 3'd0;
    push(2, 8'h00, "z0_pre");
    drain();
    tick();
    waddr = 3'd1; wdata = 8'hAA;
    tick();
    we1 = 1'b0; raddr_a = 3'd0; raddr_b = 3'd1;
    push(2, 8'h00, "z0_read"); push(3, 8'hAA, "z0_r1");
    drain();

    // DEPTH=6: writes to addresses 6 and 7 are dropped and read back as zero.
    we2 = 1'b1; waddr = 3'd5; wdata = 8'h5A;
    tick();
    waddr = 3'd7; wdata = 8'hC3; raddr_a = 3'd7;
    push(4, 8'h00, "oor_pre");
    drain();
    tick();
    waddr = 3'd6; wdata = 8'h3D;
    tick();
    we2 = 1'b0; raddr_a = 3'd7; raddr_b = 3'd6;
    push(4, 8'h00, "oor7"); push(5, 8'h00, "oor6");
    drain();
    for (int i = 0; i < 6; i++) begin
      raddr_a = 3'(i);
      push(4, (i == 5) ? 8'h5A : 8'h00, $sformatf("d6_a%0d", i));
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
